reg_file_sb: RTL and testbench

Parametrised successor register file for the RV32IM pipeline. It provides a configurable number of combinational read ports, one clocked write-back port with optional write-through bypass, and a per-register pending-write scoreboard. The decode stage uses it to read operands and detect hazards against outstanding multi-cycle results (MUL/DIV, loads). The write-back stage retires results into it. Register 0 is hardwired to zero.

---
 rtl/reg_file_sb.sv | 95 +++++++++
 tb/tb_reg_file_sb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Register file with combinational read ports, one write-back port and a per-register pending-write scoreboard.
// Reads are zero-latency; writes and issues take effect on the next edge; ISSUE_READY deasserts when a counter is full.
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int CNT_WIDTH  = 2,
    parameter int BYPASS     = 1
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] READ_ADDRESS,
    output logic [NUM_READ*DATA_WIDTH-1:0] READ_DATA,
    output logic [NUM_READ-1:0]            READ_BUSY,
    input  logic                           WRITE_ENABLE,
    input  logic [ADDR_WIDTH-1:0]          WRITE_ADDRESS,
    input  logic [DATA_WIDTH-1:0]          WRITE_DATA,
    input  logic                           WRITE_CLEAR,
    input  logic                           ISSUE_ENABLE,
    input  logic [ADDR_WIDTH-1:0]          ISSUE_ADDRESS,
    output logic                           ISSUE_READY,
    output logic                           ERROR
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [CNT_WIDTH-1:0]  cnt_q  [DEPTH];
    logic [CNT_WIDTH-1:0]  cnt_d  [DEPTH];
    logic                  error_q, error_d;

    logic wr_fire, clr_fire, issue_fire, same_addr;

    assign wr_fire    = WRITE_ENABLE & ~RESET;
    assign clr_fire   = wr_fire & WRITE_CLEAR & (WRITE_ADDRESS != '0);
    assign ISSUE_READY = ~RESET & ((ISSUE_ADDRESS == '0) | (cnt_q[ISSUE_ADDRESS] != CNT_MAX));
    assign issue_fire = ISSUE_ENABLE & ISSUE_READY & (ISSUE_ADDRESS != '0);
    assign same_addr  = (ISSUE_ADDRESS == WRITE_ADDRESS);
    assign ERROR      = error_q;

    // A simultaneous issue and clear to one register cancel out, without flagging underflow.
    always_comb begin
        cnt_d   = cnt_q;
        error_d = error_q;
        if (!(issue_fire && clr_fire && same_addr)) begin
            if (issue_fire) begin
                cnt_d[ISSUE_ADDRESS] = cnt_q[ISSUE_ADDRESS] + CNT_WIDTH'(1);
            end
            if (clr_fire) begin
                if (cnt_q[WRITE_ADDRESS] != '0) begin
                    cnt_d[WRITE_ADDRESS] = cnt_q[WRITE_ADDRESS] - CNT_WIDTH'(1);
                end else begin
                    error_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < DEPTH; k++) begin
                cnt_q[k]  <= '0;
                regs_q[k] <= '0;
            end
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= error_d;
            if (wr_fire && (WRITE_ADDRESS != '0)) begin
                regs_q[WRITE_ADDRESS] <= WRITE_DATA;
            end
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  clr_a;
        logic [CNT_WIDTH-1:0]  cnt_eff;

        assign ra      = READ_ADDRESS[i*ADDR_WIDTH +: ADDR_WIDTH];
        // Without bypass, a same-cycle clear only becomes visible after the edge.
        assign clr_a   = (BYPASS != 0) & clr_fire & (WRITE_ADDRESS == ra) & (cnt_q[ra] != '0);
        assign cnt_eff = cnt_q[ra] - {{(CNT_WIDTH-1){1'b0}}, clr_a};

        always_comb begin
            READ_DATA[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[ra];
            READ_BUSY[i]                          = (ra != '0) & (cnt_eff != '0);
            if (ra == '0) begin
                READ_DATA[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if ((BYPASS != 0) && wr_fire && (WRITE_ADDRESS == ra)) begin
                READ_DATA[i*DATA_WIDTH +: DATA_WIDTH] = WRITE_DATA;
            end
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a bypassing and a non-bypassing instance share all stimulus.
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] ra;
    logic        we, wc, ie;
    logic [4:0]  wa, ia;
    logic [31:0] wd;

    logic [95:0] rd_b, rd_n;
    logic [2:0]  bz_b, bz_n;
    logic        ir_b, ir_n, er_b, er_n;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(3), .CNT_WIDTH(2), .BYPASS(1)) dut_b (
        .CLK(clk), .RESET(rst), .READ_ADDRESS(ra), .READ_DATA(rd_b), .READ_BUSY(bz_b),
        .WRITE_ENABLE(we), .WRITE_ADDRESS(wa), .WRITE_DATA(wd), .WRITE_CLEAR(wc),
        .ISSUE_ENABLE(ie), .ISSUE_ADDRESS(ia), .ISSUE_READY(ir_b), .ERROR(er_b)
    );

    reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(3), .CNT_WIDTH(2), .BYPASS(0)) dut_n (
        .CLK(clk), .RESET(rst), .READ_ADDRESS(ra), .READ_DATA(rd_n), .READ_BUSY(bz_n),
        .WRITE_ENABLE(we), .WRITE_ADDRESS(wa), .WRITE_DATA(wd), .WRITE_CLEAR(wc),
        .ISSUE_ENABLE(ie), .ISSUE_ADDRESS(ia), .ISSUE_READY(ir_n), .ERROR(er_n)
    );

    // Selector codes: 0-2 data_b port, 3-5 data_n port, 6-8 busy_b, 9-11 busy_n,
    // 12 ready_b, 13 ready_n, 14 error_b, 15 error_n.
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0, 1, 2:   return rd_b[sel*32 +: 32];
            3, 4, 5:   return rd_n[(sel-3)*32 +: 32];
            6, 7, 8:   return {31'd0, bz_b[sel-6]};
            9, 10, 11: return {31'd0, bz_n[sel-9]};
            12:        return {31'd0, ir_b};
            13:        return {31'd0, ir_n};
            14:        return {31'd0, er_b};
            default:   return {31'd0, er_n};
        endcase
    endfunction

    function automatic void expect_v(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name; e.sel = sel; e.exp = v;
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wc = 1'b0; wa = '0; wd = '0; ie = 1'b0; ia = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        we = 1'b1; wc = 1'b1; wa = 5'd5; wd = 32'hFFFF_FFFF; ie = 1'b1; ia = 5'd3;
        ra = {5'd5, 5'd3, 5'd5};
        tick();
        #2;
        for (int p = 0; p < 3; p++) begin
            expect_v("rst_data_b", p, 32'd0);
            expect_v("rst_busy_b", 6 + p, 32'd0);
            expect_v("rst_busy_n", 9 + p, 32'd0);
        end
        expect_v("rst_ready_b", 12, 32'd0);
        expect_v("rst_ready_n", 13, 32'd0);
        expect_v("rst_err_b", 14, 32'd0);
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            n_cmp++;
            if (obs(e.sel) !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
            end
        end
        tick();
        rst = 1'b0;
        idle();
        #2;
        expect_v("post_rst_ready_b", 12, 32'd1);
        expect_v("post_rst_ready_n", 13, 32'd1);
        expect_v("post_rst_data_n", 3, 32'd0);
        expect_v("post_rst_err_n", 15, 32'd0);
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            n_cmp++;
            if (obs(e.sel) !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
            end
        end
    endtask

    task automatic test_bypass();
        tick();
        ra = {5'd0, 5'd0, 5'd5};
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
        #2;
        expect_v("byp_same_b", 0, 32'hDEAD_BEEF);
        expect_v("byp_same_n", 3, 32'd0);
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            n_cmp++;
            if (obs(e.sel) !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
            end
        end
        tick();
        idle();
        #2;
        expect_v("byp_next_b", 0, 32'hDEAD_BEEF);
        expect_v("byp_next_n", 3, 32'hDEAD_BEEF);
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            n_cmp++;
            if (obs(e.sel) !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
            end
        end
    endtask

    task automatic test_x0();
        ra = {5'd0, 5'd0, 5'd0};
        we = 1'b1; wa = 5'd0; wd = 32'h0000_1234; ie = 1'b1; ia = 5'd0;
        for (int k = 0; k < 3; k++) begin
            #2;
            expect_v("x0_data_b", 0, 32'd0);
            expect_v("x0_busy_b", 6, 32'd0);
            expect_v("x0_busy_n", 9, 32'd0);
            expect_v("x0_ready_b", 12, 32'd1);
            while (exp_q.size() > 0) begin
                exp_t e = exp_q.pop_front();
                n_cmp++;
                if (obs(e.sel) !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
                end
            end
            tick();
        end
        idle();
        #2;
        expect_v("x0_after_data_n", 3, 32'd0);
        expect_v("x0_after_ready_n", 13, 32'd1);
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            n_cmp++;
            if (obs(e.sel) !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
            end
        end
    endtask

    // One step of the saturation sequence: drive, then check ready/busy on x7.
    task automatic sat_step(input logic i_en, input logic c_en, input logic [31:0] e_rdy,
                            input logic [31:0] e_bb, input logic [31:0] e_bn, input string nm);
        tick();
        ie = i_en; ia = 5'd7;
        we = c_en; wc = c_en; wa = 5'd7; wd = 32'h0000_0070;
        #2;
        expect_v({nm, "_ready_b"}, 12, e_rdy);
        expect_v({nm, "_busy_b"}, 6, e_bb);
        expect_v({nm, "_busy_n"}, 9, e_bn);
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            n_cmp++;
            if (obs(e.sel) !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
            end
        end
    endtask

    task automatic test_saturation();
        ra = {5'd0, 5'd0, 5'd7};
        sat_step(1'b1, 1'b0, 1, 0, 0, "sat_c0");
        sat_step(1'b1, 1'b0, 1, 1, 1, "sat_c1");
        sat_step(1'b1, 1'b1, 1, 1, 1, "sat_c2_issclr");
        sat_step(1'b1, 1'b0, 1, 1, 1, "sat_c2_hold");
        sat_step(1'b1, 1'b1, 0, 1, 1, "sat_c3_full");
        sat_step(1'b0, 1'b1, 1, 1, 1, "sat_c2_clr");
        sat_step(1'b0, 1'b1, 1, 0, 1, "sat_c1_lastclr");
        sat_step(1'b0, 1'b0, 1, 0, 0, "sat_c0_idle");
        expect_v("sat_data_n", 3, 32'h0000_0070);
        expect_v("sat_err_b", 14, 32'd0);
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            n_cmp++;
            if (obs(e.sel) !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
            end
        end
    endtask

    task automatic test_underflow();
        tick();
        we = 1'b1; wc = 1'b1; wa = 5'd9; wd = 32'h9;
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            #2;
            expect_v("uf_err_b", 14, 32'd1);
            expect_v("uf_err_n", 15, 32'd1);
            while (exp_q.size() > 0) begin
                exp_t e = exp_q.pop_front();
                n_cmp++;
                if (obs(e.sel) !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
                end
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ra = {5'd0, 5'd0, 5'd5};
        #2;
        expect_v("uf_rst_err_b", 14, 32'd0);
        expect_v("uf_rst_err_n", 15, 32'd0);
        expect_v("uf_rst_x5_n", 3, 32'd0);
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            n_cmp++;
            if (obs(e.sel) !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
            end
        end
    endtask

    task automatic test_multiport();
        tick();
        we = 1'b1; wa = 5'd1; wd = 32'h1111_1111;
        tick();
        idle();
        ie = 1'b1; ia = 5'd2;
        tick();
        ia = 5'd1;
        tick();
        idle();
        ra = {5'd1, 5'd2, 5'd1};
        we = 1'b1; wc = 1'b1; wa = 5'd2; wd = 32'hA5A5_A5A5;
        #2;
        expect_v("mp_d0_b", 0, 32'h1111_1111);
        expect_v("mp_d1_b", 1, 32'hA5A5_A5A5);
        expect_v("mp_d2_b", 2, 32'h1111_1111);
        expect_v("mp_d1_n", 4, 32'd0);
        expect_v("mp_d2_n", 5, 32'h1111_1111);
        expect_v("mp_bz0_b", 6, 32'd1);
        expect_v("mp_bz1_b", 7, 32'd0);
        expect_v("mp_bz2_b", 8, 32'd1);
        expect_v("mp_bz1_n", 10, 32'd1);
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            n_cmp++;
            if (obs(e.sel) !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
            end
        end
        tick();
        idle();
        #2;
        expect_v("mp_next_d1_n", 4, 32'hA5A5_A5A5);
        expect_v("mp_next_bz1_n", 10, 32'd0);
        expect_v("mp_next_bz2_n", 11, 32'd1);
        expect_v("mp_next_err_b", 14, 32'd0);
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            n_cmp++;
            if (obs(e.sel) !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        ra  = '0;
        idle();
        test_reset();
        test_bypass();
        test_x0();
        test_saturation();
        test_underflow();
        test_multiport();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
